// File: rtl/mage_stream_dma_ch.sv
// mage_stream_dma_ch: memory-side master for one Mage HW-FIFO channel.
// Streams memory words into the channel FIFO, or FIFO results to memory.
module mage_stream_dma_ch #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32,
  parameter int LEN_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              start_i,
  input  logic              dir_i,
  input  logic [ADDR_W-1:0] base_addr_i,
  input  logic [LEN_W-1:0]  len_i,
  input  logic              abort_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [31:0]       mem_wdata_o,
  input  logic              mem_gnt_i,
  input  logic              mem_rvalid_i,
  input  logic [31:0]       mem_rdata_i,
  output logic              fifo_push_o,
  output logic [31:0]       fifo_data_o,
  input  logic              fifo_full_i,
  output logic              fifo_pop_o,
  input  logic [31:0]       fifo_data_i,
  input  logic              fifo_empty_i
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE, S_READ, S_WRITE, S_DRAIN, S_DONE
  } state_e;

  state_e            state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  issued_q;
  logic [LEN_W-1:0]  pushed_q;
  logic [LEN_W-1:0]  popped_q;
  logic [LEN_W-1:0]  written_q;
  logic [LEN_W-1:0]  written_d;
  logic [CW-1:0]     outst_q;
  logic [CW-1:0]     outst_d;
  logic [CW-1:0]     cnt_q;
  logic [CW-1:0]     cnt_d;
  logic [PW-1:0]     wr_ptr_q;
  logic [PW-1:0]     rd_ptr_q;
  logic [31:0]       rbuf_q [DEPTH];
  logic [31:0]       hold_q;
  logic              hold_v_q;

  logic rd_req;
  logic wr_req;
  logic gnt;
  logic store;
  logic push;
  logic pop;

  // Handshake decisions; abort blocks FIFO traffic in its own cycle.
  always_comb begin
    rd_req = (state_q == S_READ) && (issued_q < len_q) &&
             (({1'b0, outst_q} + {1'b0, cnt_q}) < DEPTH_C);
    wr_req = (state_q == S_WRITE) && hold_v_q;
    gnt    = (rd_req || wr_req) && mem_gnt_i;
    store  = (state_q == S_READ) && mem_rvalid_i;
    push   = (state_q == S_READ) && !abort_i &&
             (cnt_q != '0) && !fifo_full_i;
    pop    = (state_q == S_WRITE) && !abort_i && !fifo_empty_i &&
             (!hold_v_q || gnt) && (popped_q < len_q);
    written_d = written_q + LEN_W'(wr_req && mem_gnt_i);
    outst_d = outst_q;
    unique case ({gnt, mem_rvalid_i})
      2'b10:   outst_d = outst_q + CW'(1);
      2'b01:   outst_d = outst_q - CW'(1);
      default: outst_d = outst_q;
    endcase
    cnt_d = cnt_q;
    unique case ({store, push})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  assign busy_o      = (state_q != S_IDLE);
  assign done_o      = (state_q == S_DONE);
  assign mem_req_o   = rd_req || wr_req;
  assign mem_we_o    = (state_q == S_WRITE);
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = hold_q;
  assign fifo_push_o = push;
  assign fifo_data_o = rbuf_q[rd_ptr_q];
  assign fifo_pop_o  = pop;

  // Transfer FSM with its counters, read buffer and write hold register.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      len_q     <= '0;
      issued_q  <= '0;
      pushed_q  <= '0;
      popped_q  <= '0;
      written_q <= '0;
      outst_q   <= '0;
      cnt_q     <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      hold_q    <= '0;
      hold_v_q  <= 1'b0;
      for (int i = 0; i < DEPTH; i++) rbuf_q[i] <= '0;
    end else begin
      outst_q   <= outst_d;
      cnt_q     <= cnt_d;
      written_q <= written_d;
      if (gnt) addr_q <= addr_q + ADDR_W'(4);
      if (rd_req && mem_gnt_i) issued_q <= issued_q + LEN_W'(1);
      if (store) begin
        rbuf_q[wr_ptr_q] <= mem_rdata_i;
        wr_ptr_q         <= wr_ptr_q + PW'(1);
      end
      if (push) begin
        rd_ptr_q <= rd_ptr_q + PW'(1);
        pushed_q <= pushed_q + LEN_W'(1);
      end
      if (pop) begin
        hold_q   <= fifo_data_i;
        hold_v_q <= 1'b1;
        popped_q <= popped_q + LEN_W'(1);
      end else if (wr_req && mem_gnt_i) begin
        hold_v_q <= 1'b0;
      end
      unique case (state_q)
        S_IDLE: begin
          if (start_i) begin
            addr_q    <= base_addr_i;
            len_q     <= len_i;
            issued_q  <= '0;
            pushed_q  <= '0;
            popped_q  <= '0;
            written_q <= '0;
            if (len_i == '0) state_q <= S_DONE;
            else if (dir_i)  state_q <= S_WRITE;
            else             state_q <= S_READ;
          end
        end
        S_READ: begin
          if (abort_i) state_q <= S_DRAIN;
          else if (push && (pushed_q + LEN_W'(1) == len_q))
            state_q <= S_DONE;
        end
        S_WRITE: begin
          if (abort_i) state_q <= S_DRAIN;
          else if ((written_d == len_q) && (outst_d == '0))
            state_q <= S_DONE;
        end
        S_DRAIN: begin
          cnt_q    <= '0;
          wr_ptr_q <= '0;
          rd_ptr_q <= '0;
          hold_v_q <= 1'b0;
          if (outst_q == '0) state_q <= S_IDLE;
        end
        S_DONE: state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mage_stream_dma_ch.sv
// tb_mage_stream_dma_ch: random bus/FIFO environment for the DMA channel.
// Expected traffic is derived from base, length and the source data only.
module tb_mage_stream_dma_ch;

  logic        clk = 1'b0;
  logic        rst_n_i;
  logic        start_i;
  logic        dir_i;
  logic [31:0] base_addr_i;
  logic [15:0] len_i;
  logic        abort_i;
  logic        busy_o;
  logic        done_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic        mem_gnt_i;
  logic        mem_rvalid_i;
  logic [31:0] mem_rdata_i;
  logic        fifo_push_o;
  logic [31:0] fifo_data_o;
  logic        fifo_full_i;
  logic        fifo_pop_o;
  logic [31:0] fifo_data_i;
  logic        fifo_empty_i;

  always #5 clk = ~clk;

  mage_stream_dma_ch dut (
    .clk_i        (clk),
    .rst_n_i      (rst_n_i),
    .start_i      (start_i),
    .dir_i        (dir_i),
    .base_addr_i  (base_addr_i),
    .len_i        (len_i),
    .abort_i      (abort_i),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .mem_req_o    (mem_req_o),
    .mem_we_o     (mem_we_o),
    .mem_addr_o   (mem_addr_o),
    .mem_wdata_o  (mem_wdata_o),
    .mem_gnt_i    (mem_gnt_i),
    .mem_rvalid_i (mem_rvalid_i),
    .mem_rdata_i  (mem_rdata_i),
    .fifo_push_o  (fifo_push_o),
    .fifo_data_o  (fifo_data_o),
    .fifo_full_i  (fifo_full_i),
    .fifo_pop_o   (fifo_pop_o),
    .fifo_data_i  (fifo_data_i),
    .fifo_empty_i (fifo_empty_i)
  );

  typedef struct {
    logic [31:0] data;
    int          rdy;
  } rsp_t;

  int n_tests = 0;
  int n_fail  = 0;

  rsp_t        rsp_q[$];
  logic [31:0] exp_push[$];
  logic [31:0] exp_wr[$];
  logic [31:0] src_q[$];

  int gnt_pct, full_pct, empty_pct, lat_lo, lat_hi, full_force;
  int cyc, done_cnt, act, mo, mb, done_k;
  bit wmode, post_abort, aborted, hold_pend, rv_now, busy_s, done_s;
  logic [31:0] exp_addr, hold_addr, hold_wd;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'hA0 + ((a - 32'h1000) >> 2);
  endfunction

  task automatic sample();
    bit   g;
    rsp_t r;
    busy_s = busy_o;
    done_s = done_o;
    g = mem_req_o && mem_gnt_i;
    if (mem_req_o || fifo_push_o || fifo_pop_o) act++;
    if (done_o) begin
      done_cnt++;
      chk("done_rsp", rsp_q.size(), 0);
    end
    if (hold_pend && !post_abort) begin
      chk("req_hold", mem_req_o, 1);
      chk("addr_hold", mem_addr_o, hold_addr);
      chk("wdata_hold", mem_wdata_o, hold_wd);
    end
    hold_pend = mem_req_o && !mem_gnt_i;
    hold_addr = mem_addr_o;
    hold_wd   = mem_wdata_o;
    if (post_abort) begin
      chk("ab_req", mem_req_o, 0);
      chk("ab_push", fifo_push_o, 0);
      chk("ab_pop", fifo_pop_o, 0);
    end else begin
      if (g) begin
        chk("we", mem_we_o, wmode);
        chk("addr", mem_addr_o, exp_addr);
        exp_addr += 4;
        if (wmode) begin
          if (exp_wr.size() == 0) chk("wr_extra", 1, 0);
          else chk("wdata", mem_wdata_o, exp_wr.pop_front());
        end else begin
          chk("rd_bound", (mo + mb) < 4, 1);
        end
        r.data = wmode ? 32'h0 : mem_word(mem_addr_o);
        r.rdy  = cyc + 1 + int'($urandom_range(lat_hi, lat_lo));
        rsp_q.push_back(r);
      end
      if (fifo_push_o) begin
        chk("push_full", fifo_full_i, 0);
        if (exp_push.size() == 0) chk("push_extra", 1, 0);
        else chk("push_data", fifo_data_o, exp_push.pop_front());
      end
      if (fifo_pop_o) begin
        chk("pop_empty", fifo_empty_i, 0);
        if (src_q.size() > 0) void'(src_q.pop_front());
      end
      if (abort_i && busy_s && !done_s) begin
        chk("ab_push_cyc", fifo_push_o, 0);
        chk("ab_pop_cyc", fifo_pop_o, 0);
        post_abort = 1;
        aborted    = 1;
      end
    end
    if (g) mo++;
    if (rv_now) begin
      mo--;
      if (!wmode) mb++;
    end
    if (fifo_push_o) mb--;
  endtask

  task automatic cycle();
    mem_gnt_i = ($urandom_range(99) < gnt_pct);
    rv_now = 0;
    mem_rdata_i = $urandom;
    if (rsp_q.size() > 0 && rsp_q[0].rdy <= cyc) begin
      rv_now = 1;
      mem_rdata_i = rsp_q[0].data;
      void'(rsp_q.pop_front());
    end
    mem_rvalid_i = rv_now;
    fifo_full_i = (full_force > 0) || ($urandom_range(99) < full_pct);
    if (full_force > 0) full_force--;
    fifo_empty_i = (src_q.size() == 0) || ($urandom_range(99) < empty_pct);
    fifo_data_i = (src_q.size() > 0) ? src_q[0] : $urandom;
    @(negedge clk);
    sample();
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic setup(input bit d, input logic [31:0] base, input int len);
    logic [31:0] w;
    wmode = d;
    exp_addr = base;
    exp_push.delete();
    exp_wr.delete();
    src_q.delete();
    mo = 0;
    mb = 0;
    post_abort = 0;
    aborted = 0;
    hold_pend = 0;
    act = 0;
    done_k = -1;
    if (!d) begin
      for (int i = 0; i < len; i++) exp_push.push_back(mem_word(base + 4*i));
    end else begin
      for (int i = 0; i < len + 2; i++) begin
        w = $urandom;
        src_q.push_back(w);
        if (i < len) exp_wr.push_back(w);
      end
    end
    start_i = 1;
    dir_i = d;
    base_addr_i = base;
    len_i = len[15:0];
  endtask

  task automatic xfer(input bit d, input logic [31:0] base, input int len,
                      input int abort_at, input int restart_at);
    int db;
    db = done_cnt;
    setup(d, base, len);
    cycle();
    start_i = 0;
    dir_i = ~d;
    base_addr_i = $urandom;
    len_i = 16'($urandom_range(40, 1));
    for (int k = 1; k <= 2000; k++) begin
      abort_i = (k == abort_at);
      start_i = (k == restart_at) && busy_o;
      cycle();
      if (done_s && done_k < 0) done_k = k;
      if (!busy_s) break;
    end
    abort_i = 0;
    start_i = 0;
    chk("timeout", busy_s, 0);
    if (aborted) begin
      chk("ab_done", done_cnt - db, 0);
      chk("ab_rsp", rsp_q.size(), 0);
    end else begin
      chk("done_cnt", done_cnt - db, 1);
      chk("push_left", exp_push.size(), 0);
      chk("wr_left", exp_wr.size(), 0);
      if (d) chk("src_left", src_q.size(), 2);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ctl"}, {26'b0, busy_o, done_o, mem_req_o, mem_we_o,
                        fifo_push_o, fifo_pop_o}, 0);
    chk({tag, "_addr"}, mem_addr_o, 0);
    chk({tag, "_wdata"}, mem_wdata_o, 0);
    chk({tag, "_fdata"}, fifo_data_o, 0);
  endtask

  initial begin
    int db;
    rst_n_i = 0;
    start_i = 0;
    dir_i = 0;
    base_addr_i = 0;
    len_i = 0;
    abort_i = 0;
    mem_gnt_i = 0;
    mem_rvalid_i = 0;
    mem_rdata_i = 0;
    fifo_full_i = 0;
    fifo_data_i = 0;
    fifo_empty_i = 1;
    cyc = 0;
    done_cnt = 0;
    full_force = 0;
    repeat (2) @(posedge clk);
    #1;
    chk_zero("reset");
    rst_n_i = 1;

    gnt_pct = 100; full_pct = 0; empty_pct = 0; lat_lo = 0; lat_hi = 0;
    xfer(0, 32'h1000, 5, 0, 0);

    lat_hi = 2; full_force = 10;
    xfer(0, 32'h1400, 8, 0, 0);

    gnt_pct = 35;
    xfer(1, 32'h2000, 3, 0, 0);

    gnt_pct = 100;
    xfer(0, 32'h1800, 0, 0, 0);
    chk("len0_done_k", done_k, 1);
    chk("len0_act", act, 0);

    lat_lo = 6; lat_hi = 6;
    xfer(0, 32'h1100, 10, 3, 0);
    chk("ab_flag", aborted, 1);
    lat_lo = 0; lat_hi = 1;
    xfer(0, 32'h1200, 6, 0, 0);

    gnt_pct = 60;
    xfer(1, 32'h2400, 6, 0, 3);

    db = done_cnt;
    gnt_pct = 50;
    setup(1, 32'h3000, 6);
    cycle();
    start_i = 0;
    repeat (4) cycle();
    chk("rst_busy_pre", busy_s, 1);
    rst_n_i = 0;
    #1;
    chk_zero("midrst");
    mem_rvalid_i = 0;
    @(posedge clk);
    #1;
    rsp_q.delete();
    rst_n_i = 1;
    chk("rst_nodone", done_cnt - db, 0);
    xfer(1, 32'h3100, 4, 0, 0);

    for (int t = 0; t < 25; t++) begin
      gnt_pct   = $urandom_range(100, 30);
      full_pct  = $urandom_range(50, 0);
      empty_pct = $urandom_range(50, 0);
      lat_lo    = 0;
      lat_hi    = $urandom_range(4, 0);
      xfer($urandom_range(1, 0), $urandom & 32'h0000_FFFC,
           $urandom_range(16, 1),
           ($urandom_range(3, 0) == 0) ? $urandom_range(12, 1) : 0,
           ($urandom_range(2, 0) == 0) ? $urandom_range(8, 2) : 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
